interrupt_controller: RTL and testbench



---
 rtl/interrupt_controller.sv | 158 +++++++++++++++
 tb/tb_interrupt_controller.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : interrupt_controller
//  Description : Fixed-priority interrupt controller. Peripheral requests are
//                synchronized and edge-detected into a pending register. The
//                lowest-index pending source that is also enabled in the mask
//                is presented to the CPU control unit as irq/vector. The
//                request is held until the control unit returns ack. Mask
//                (R/W) and flag (read = pending, write-1-to-clear) registers
//                sit in I/O space on the shared bus.
//  Ports       : clk, reset        - clock, asynchronous active-high reset
//                irq_src           - raw requests, rising edge = event
//                irq, vector       - registered request and ISR address
//                ack               - one-cycle retire pulse from control unit
//                bus_addr,bus_data - I/O address and tri-state data
//                io_cs,io_we,io_oe - I/O select, write strobe, read strobe
//  Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter int                    NUM_IRQ      = 8,
    parameter int                    DATA_WIDTH   = 8,
    parameter int                    ADDR_WIDTH   = 16,
    parameter int                    I_ADDR_WIDTH = 10,
    parameter int                    VECTOR_BASE  = 1,
    parameter logic [ADDR_WIDTH-1:0] IMSK_ADDR    = 16'h003B,
    parameter logic [ADDR_WIDTH-1:0] IFLG_ADDR    = 16'h003A
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_IRQ-1:0]      irq_src,
    output logic                    irq,
    output logic [I_ADDR_WIDTH-1:0] vector,
    input  logic                    ack,
    input  logic [ADDR_WIDTH-1:0]   bus_addr,
    inout  wire  [DATA_WIDTH-1:0]   bus_data,
    input  logic                    io_cs,
    input  logic                    io_we,
    input  logic                    io_oe
);

    localparam int       c_SEL_W   = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
    localparam logic [0:0] c_IDLE    = 1'b0;
    localparam logic [0:0] c_PRESENT = 1'b1;

    logic [NUM_IRQ-1:0]      r_sync1;
    logic [NUM_IRQ-1:0]      r_sync2;
    logic [NUM_IRQ-1:0]      r_prev;
    logic [NUM_IRQ-1:0]      r_pending;
    logic [NUM_IRQ-1:0]      r_imsk;
    logic [0:0]              r_state;
    logic [c_SEL_W-1:0]      r_sel;
    logic                    r_irq;
    logic [I_ADDR_WIDTH-1:0] r_vector;

    logic [NUM_IRQ-1:0]      w_rise;
    logic [NUM_IRQ-1:0]      w_elig;
    logic [NUM_IRQ-1:0]      w_ack_clr;
    logic [NUM_IRQ-1:0]      w_w1c_clr;
    logic [c_SEL_W-1:0]      w_sel;
    logic                    w_imsk_hit;
    logic                    w_iflg_hit;
    logic                    w_rd_en;
    logic [DATA_WIDTH-1:0]   w_rd_data;

    assign w_rise     = r_sync2 & ~r_prev;
    assign w_elig     = r_pending & r_imsk;
    assign w_imsk_hit = io_cs && (bus_addr == IMSK_ADDR);
    assign w_iflg_hit = io_cs && (bus_addr == IFLG_ADDR);
    assign w_w1c_clr  = (w_iflg_hit && io_we) ? bus_data[NUM_IRQ-1:0] : '0;

    // Scan from the top down so the lowest eligible index is the last match.
    always_comb begin
        w_sel = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_sel = c_SEL_W'(i);
            end
        end
    end

    // Ack retires the committed source only; an ack in IDLE clears nothing.
    always_comb begin
        w_ack_clr = '0;
        if ((r_state == c_PRESENT) && ack) begin
            w_ack_clr[r_sel] = 1'b1;
        end
    end

    // Input path, pending and mask registers. A new edge is OR-ed in after
    // the clears so a coincident set always wins.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1   <= '0;
            r_sync2   <= '0;
            r_prev    <= '0;
            r_pending <= '0;
            r_imsk    <= '0;
        end else begin
            r_sync1   <= irq_src;
            r_sync2   <= r_sync1;
            r_prev    <= r_sync2;
            r_pending <= (r_pending & ~(w_ack_clr | w_w1c_clr)) | w_rise;
            if (w_imsk_hit && io_we) begin
                r_imsk <= bus_data[NUM_IRQ-1:0];
            end
        end
    end

    // Request FSM. In PRESENT the selection is committed: mask changes or a
    // W1C of the flag do not withdraw irq.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= c_IDLE;
            r_sel    <= '0;
            r_irq    <= 1'b0;
            r_vector <= '0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (|w_elig) begin
                        r_sel    <= w_sel;
                        r_irq    <= 1'b1;
                        r_vector <= I_ADDR_WIDTH'(VECTOR_BASE) + I_ADDR_WIDTH'(w_sel);
                        r_state  <= c_PRESENT;
                    end
                end
                c_PRESENT: begin
                    if (ack) begin
                        r_irq   <= 1'b0;
                        r_state <= c_IDLE;
                    end
                end
                default: begin
                    r_irq   <= 1'b0;
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

    assign irq    = r_irq;
    assign vector = r_vector;

    // Read data is zero-extended; the bus is released during reset.
    always_comb begin
        w_rd_data = '0;
        if (w_imsk_hit) begin
            w_rd_data[NUM_IRQ-1:0] = r_imsk;
        end else if (w_iflg_hit) begin
            w_rd_data[NUM_IRQ-1:0] = r_pending;
        end
    end

    assign w_rd_en  = io_oe && (w_imsk_hit || w_iflg_hit) && !reset;
    assign bus_data = w_rd_en ? w_rd_data : {DATA_WIDTH{1'bz}};

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_interrupt_controller
//  Description : Self-checking bench for interrupt_controller. Directed
//                scenarios plus randomized request bursts; expected vectors
//                are queued when stimulus is issued and popped by a monitor
//                on each new irq presentation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    localparam logic [15:0] IMSK = 16'h003B;
    localparam logic [15:0] IFLG = 16'h003A;
    localparam int          VBASE = 1;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  irq_src = '0;
    logic        irq;
    logic [9:0]  vector;
    logic        ack = 1'b0;
    logic [15:0] bus_addr = '0;
    wire  [7:0]  bus_data;
    logic        io_cs = 1'b0;
    logic        io_we = 1'b0;
    logic        io_oe = 1'b0;
    logic        drv_en = 1'b0;
    logic [7:0]  drv_val = '0;

    int checks = 0;
    int failures = 0;
    int exp_q[$];
    bit mon_en = 1'b0;

    assign bus_data = drv_en ? drv_val : 8'bz;

    interrupt_controller dut (
        .clk      (clk),
        .reset    (reset),
        .irq_src  (irq_src),
        .irq      (irq),
        .vector   (vector),
        .ack      (ack),
        .bus_addr (bus_addr),
        .bus_data (bus_data),
        .io_cs    (io_cs),
        .io_we    (io_we),
        .io_oe    (io_oe)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic bus_write(input logic [15:0] a, input logic [7:0] d);
        bus_addr = a; drv_val = d; drv_en = 1'b1; io_cs = 1'b1; io_we = 1'b1;
        tick();
        io_cs = 1'b0; io_we = 1'b0; drv_en = 1'b0;
    endtask

    task automatic chk_rd(input string name, input logic [15:0] a, input logic [7:0] exp);
        logic [7:0] d;
        bus_addr = a; io_cs = 1'b1; io_oe = 1'b1;
        #1;
        d = bus_data;
        io_cs = 1'b0; io_oe = 1'b0;
        chk(name, {24'd0, d}, {24'd0, exp});
    endtask

    // One-cycle source pulse followed by enough idle cycles for the
    // event to reach pending and, if enabled, irq.
    task automatic pulse_src(input logic [7:0] m);
        irq_src = m;
        tick();
        irq_src = '0;
        tick(3);
    endtask

    task automatic do_ack();
        ack = 1'b1;
        tick();
        ack = 1'b0;
    endtask

    // Monitor: each rising edge of irq is one presentation, compared
    // against the oldest outstanding expectation.
    initial begin
        logic irq_q;
        int   e;
        irq_q = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (mon_en && irq && !irq_q) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_irq actual=%0d required=none", vector);
                end else begin
                    e = exp_q.pop_front();
                    chk("rand_vector", {22'd0, vector}, e);
                end
            end
            irq_q = irq;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] mask, srcs, elig;
        int n, t;

        // Reset state
        tick(3);
        chk("rst_irq", {31'd0, irq}, 0);
        chk("rst_vector", {22'd0, vector}, 0);
        reset = 1'b0;
        tick();
        chk_rd("rst_imsk", IMSK, 8'h00);
        chk_rd("rst_iflg", IFLG, 8'h00);

        // Basic request with exact 4-cycle latency
        bus_write(IMSK, 8'h04);
        irq_src = 8'h04;
        tick();
        irq_src = '0;
        tick(2);
        chk("basic_not_early", {31'd0, irq}, 0);
        tick();
        chk("basic_irq", {31'd0, irq}, 1);
        chk("basic_vector", {22'd0, vector}, 3);
        do_ack();
        chk("basic_ack_drop", {31'd0, irq}, 0);
        chk_rd("basic_iflg", IFLG, 8'h00);

        // Priority and freeze
        bus_write(IMSK, 8'hFF);
        pulse_src(8'h22);
        chk("prio_irq", {31'd0, irq}, 1);
        chk("prio_vector", {22'd0, vector}, 2);
        pulse_src(8'h01);
        tick();
        chk("freeze_vector", {22'd0, vector}, 2);
        do_ack();
        chk("prio_gap", {31'd0, irq}, 0);
        tick();
        chk("prio_second", {22'd0, vector}, 1);
        do_ack();
        tick();
        chk("prio_third", {22'd0, vector}, 6);
        do_ack();
        chk_rd("prio_iflg", IFLG, 8'h00);

        // Masking and late enable
        bus_write(IMSK, 8'h00);
        pulse_src(8'h08);
        tick();
        chk_rd("mask_iflg", IFLG, 8'h08);
        chk("mask_irq", {31'd0, irq}, 0);
        // Bus must float with the read strobe low or on a foreign address
        drv_en = 1'b1; drv_val = 8'h00; bus_addr = IFLG; io_cs = 1'b1;
        #1;
        chk("float_no_oe", {24'd0, bus_data}, 0);
        bus_addr = 16'h003C; io_oe = 1'b1;
        #1;
        chk("float_bad_addr", {24'd0, bus_data}, 0);
        io_cs = 1'b0; io_oe = 1'b0; drv_en = 1'b0;
        bus_write(IMSK, 8'h08);
        chk("late_en_wait", {31'd0, irq}, 0);
        tick();
        chk("late_en_irq", {31'd0, irq}, 1);
        chk("late_en_vector", {22'd0, vector}, 4);
        do_ack();

        // W1C colliding with a new edge on the same bit
        bus_write(IMSK, 8'h00);
        pulse_src(8'h08);
        chk_rd("w1c_setup", IFLG, 8'h08);
        irq_src = 8'h08;
        tick();
        irq_src = '0;
        tick();
        bus_write(IFLG, 8'h08);
        chk_rd("w1c_set_wins", IFLG, 8'h08);
        bus_write(IFLG, 8'h08);
        chk_rd("w1c_clear", IFLG, 8'h00);

        // Ack colliding with a new edge on the selected source
        bus_write(IMSK, 8'h08);
        pulse_src(8'h08);
        chk("ackcol_irq", {31'd0, irq}, 1);
        irq_src = 8'h08;
        tick();
        irq_src = '0;
        tick();
        do_ack();
        chk("ackcol_drop", {31'd0, irq}, 0);
        chk_rd("ackcol_pend", IFLG, 8'h08);
        tick();
        chk("ackcol_repres", {31'd0, irq}, 1);
        chk("ackcol_vector", {22'd0, vector}, 4);
        do_ack();
        chk_rd("ackcol_clear", IFLG, 8'h00);

        // Ack in IDLE is ignored
        bus_write(IMSK, 8'h00);
        pulse_src(8'h10);
        do_ack();
        chk("idle_ack_irq", {31'd0, irq}, 0);
        chk_rd("idle_ack_iflg", IFLG, 8'h10);
        bus_write(IFLG, 8'hFF);

        // Source held high produces a single event
        irq_src = 8'h40;
        tick(6);
        chk_rd("held_once", IFLG, 8'h40);
        bus_write(IFLG, 8'hFF);
        tick(13);
        chk_rd("held_no_retrig", IFLG, 8'h00);
        irq_src = '0;
        tick(4);

        // Randomized bursts
        mon_en = 1'b1;
        for (int tr = 0; tr < 30; tr++) begin
            mask = 8'($urandom);
            srcs = 8'($urandom);
            elig = srcs & mask;
            bus_write(IMSK, mask);
            for (int i = 0; i < 8; i++) begin
                if (elig[i]) exp_q.push_back(VBASE + i);
            end
            n = $countones(elig);
            irq_src = srcs;
            tick();
            irq_src = '0;
            for (int k = 0; k < n; k++) begin
                t = 0;
                while (!irq && t < 20) begin
                    tick();
                    t++;
                end
                chk("rand_irq_seen", {31'd0, irq}, 1);
                tick($urandom_range(0, 3));
                do_ack();
            end
            tick(6);
            chk("rand_idle", {31'd0, irq}, 0);
            chk("rand_drained", exp_q.size(), 0);
            exp_q.delete();
            chk_rd("rand_leftover", IFLG, srcs & ~mask);
            bus_write(IFLG, 8'hFF);
        end
        mon_en = 1'b0;

        // Asynchronous reset while PRESENT
        bus_write(IMSK, 8'hFF);
        pulse_src(8'h80);
        chk("prersT_vector", {22'd0, vector}, 8);
        #1;
        reset = 1'b1;
        #1;
        chk("arst_irq", {31'd0, irq}, 0);
        chk("arst_vector", {22'd0, vector}, 0);
        drv_en = 1'b1; drv_val = 8'hFF; bus_addr = IMSK; io_cs = 1'b1; io_oe = 1'b1;
        #1;
        chk("arst_bus_z", {24'd0, bus_data}, 32'hFF);
        io_cs = 1'b0; io_oe = 1'b0; drv_en = 1'b0;
        tick();
        reset = 1'b0;
        tick();
        chk_rd("arst_imsk", IMSK, 8'h00);
        chk_rd("arst_iflg", IFLG, 8'h00);
        chk("arst_irq_after", {31'd0, irq}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
